nlane_compress_pipe: RTL and testbench

- Parametrised successor to the fixed eight-lane compressor.
- Compresses NUM_LANES words per block, one block per cycle, through a registered classify stage and a log2(NUM_LANES)-level pipelined pairwise merge tree.
- Emits one bit-packed block with per-lane tags and a total bit length.
- Adds valid/ready backpressure with per-stage bubble collapse, a per-block bypass mode, and saturating throughput counters. Sits between the input word buffer and the output packer.

---
 rtl/nlane_compress_pipe_pkg.sv | 42 ++++
 rtl/nlane_compress_pipe_merge_stage.sv | 80 ++++++++
 rtl/nlane_compress_pipe.sv | 185 ++++++++++++++++++
 tb/tb_nlane_compress_pipe.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlane_compress_pipe_pkg.sv
// Shared definitions for the N-lane compressor: the lane tag encoding, the
// tag-to-length mapping and small helpers for the parameter and counter math.
package nlane_compress_pipe_pkg;

    typedef enum logic [1:0] {
        TAG_ZERO = 2'b00,
        TAG_B8   = 2'b01,
        TAG_B16  = 2'b10,
        TAG_RAW  = 2'b11
    } tag_e;

    // Number of payload bits a lane with this tag contributes.
    function automatic int unsigned tag_len(input tag_e t, input int unsigned dw);
        int unsigned l;
        case (t)
            TAG_ZERO: l = 0;
            TAG_B8:   l = 8;
            TAG_B16:  l = 16;
            default:  l = dw;
        endcase
        return l;
    endfunction

    // Ceiling log2, usable in constant expressions.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // a + b clamped to max; counters of up to 63 bits never overflow the sum.
    function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] max);
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[63:0];
    endfunction

endpackage

// File: rtl/nlane_compress_pipe_merge_stage.sv
// One level of the pairwise merge tree. Node 2j is the lower half and node
// 2j+1 the upper half of output node j; the upper payload is shifted up by the
// lower length so the packed bits stay contiguous from bit 0.
module cpr_merge_stage
    import nlane_compress_pipe_pkg::*;
#(
    parameter int NODE_W   = 32,
    parameter int NODE_CNT = 8,
    parameter int NODE_TW  = 2,
    parameter int LEN_W    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_valid,
    input  logic                             i_ld_next,
    output logic                             o_ld,
    output logic                             o_valid,
    input  logic [NODE_CNT*NODE_W-1:0]       i_data,
    input  logic [NODE_CNT*NODE_TW-1:0]      i_tag,
    input  logic [NODE_CNT*LEN_W-1:0]        i_len,
    output logic [NODE_CNT*NODE_W-1:0]       o_data,
    output logic [NODE_CNT*NODE_TW-1:0]      o_tag,
    output logic [(NODE_CNT/2)*LEN_W-1:0]    o_len
);

    localparam int OUT_CNT = NODE_CNT / 2;
    localparam int OUT_W   = 2 * NODE_W;
    localparam int OUT_TW  = 2 * NODE_TW;

    logic                          r_valid;
    logic [NODE_CNT*NODE_W-1:0]    r_data;
    logic [NODE_CNT*NODE_TW-1:0]   r_tag;
    logic [OUT_CNT*LEN_W-1:0]      r_len;

    logic [NODE_CNT*NODE_W-1:0]    w_m_data;
    logic [NODE_CNT*NODE_TW-1:0]   w_m_tag;
    logic [OUT_CNT*LEN_W-1:0]      w_m_len;

    // This stage may take a new block when empty or when its block leaves.
    assign o_ld    = ~r_valid | i_ld_next;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_tag   = r_tag;
    assign o_len   = r_len;

    // Merge each lower/upper pair into one node of twice the width.
    always_comb begin
        w_m_data = '0;
        w_m_tag  = '0;
        w_m_len  = '0;
        for (int j = 0; j < OUT_CNT; j++) begin
            w_m_data[j*OUT_W +: OUT_W] =
                {{NODE_W{1'b0}}, i_data[(2*j)*NODE_W +: NODE_W]} |
                ({{NODE_W{1'b0}}, i_data[(2*j+1)*NODE_W +: NODE_W]} << i_len[(2*j)*LEN_W +: LEN_W]);
            w_m_tag[j*OUT_TW +: OUT_TW] =
                {i_tag[(2*j+1)*NODE_TW +: NODE_TW], i_tag[(2*j)*NODE_TW +: NODE_TW]};
            w_m_len[j*LEN_W +: LEN_W] =
                i_len[(2*j)*LEN_W +: LEN_W] + i_len[(2*j+1)*LEN_W +: LEN_W];
        end
    end

    // Stage register: payload only moves when a valid block enters, so a
    // stalled block is held bit-for-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_tag   <= '0;
            r_len   <= '0;
        end else if (o_ld) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_m_data;
                r_tag  <= w_m_tag;
                r_len  <= w_m_len;
            end
        end
    end

endmodule

// File: rtl/nlane_compress_pipe.sv
// N-lane word compressor: registered classify stage followed by a pipelined
// pairwise merge tree whose last level is the output register.
// Handshake: a block moves across an interface on a cycle where valid and
// ready are both 1; valid never waits on ready, and a presented block holds
// its data until taken. Each stage loads when empty or when the stage after
// it loads, so bubbles collapse and a full pipe streams one block per cycle.
module nlane_compress_pipe
    import nlane_compress_pipe_pkg::*;
#(
    parameter int NUM_LANES  = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 16,
    parameter int STAT_WIDTH = 48
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            validIn,
    output logic                            readyOut,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] dataIn,
    input  logic                            bypassIn,
    output logic                            validOut,
    input  logic                            readyIn,
    output logic [NUM_LANES*DATA_WIDTH-1:0] dataOut,
    output logic [NUM_LANES*TAG_WIDTH-1:0]  tagOut,
    output logic [LEN_WIDTH-1:0]            lenOut,
    input  logic                            statClear,
    output logic [STAT_WIDTH-1:0]           statBlocks,
    output logic [STAT_WIDTH-1:0]           statBits
);

    localparam int          LOG      = int'(clog2(NUM_LANES));
    localparam int          TOT_D    = NUM_LANES * DATA_WIDTH;
    localparam int          TOT_T    = NUM_LANES * TAG_WIDTH;
    localparam logic [63:0] STAT_MAX = (64'd1 << STAT_WIDTH) - 64'd1;

    // Lane class: first match wins; bypass forces every lane raw.
    function automatic tag_e classify(input logic [DATA_WIDTH-1:0] w, input logic byp);
        tag_e t;
        if (byp)                                                   t = TAG_RAW;
        else if (w == '0)                                          t = TAG_ZERO;
        else if ((&w[DATA_WIDTH-1:7])  || !(|w[DATA_WIDTH-1:7]))   t = TAG_B8;
        else if ((&w[DATA_WIDTH-1:15]) || !(|w[DATA_WIDTH-1:15]))  t = TAG_B16;
        else                                                       t = TAG_RAW;
        return t;
    endfunction

    // Keeps only the payload bits of a lane so the packed output is zero above lenOut.
    function automatic logic [DATA_WIDTH-1:0] payload_mask(input tag_e t);
        logic [DATA_WIDTH-1:0] m;
        case (t)
            TAG_ZERO: m = '0;
            TAG_B8:   m = {{(DATA_WIDTH-8){1'b0}}, 8'hFF};
            TAG_B16:  m = {{(DATA_WIDTH-16){1'b0}}, 16'hFFFF};
            default:  m = '1;
        endcase
        return m;
    endfunction

    logic [TOT_D-1:0]               w_cls_data;
    logic [TOT_T-1:0]               w_cls_tag;
    logic [NUM_LANES*LEN_WIDTH-1:0] w_cls_len;
    logic                           w_ld0;
    logic                           w_fire;

    logic                           r_v0;
    logic [TOT_D-1:0]               r_d0;
    logic [TOT_T-1:0]               r_t0;
    logic [NUM_LANES*LEN_WIDTH-1:0] r_l0;
    logic [STAT_WIDTH-1:0]          r_stat_blocks;
    logic [STAT_WIDTH-1:0]          r_stat_bits;

    // Per-lane tag, length and masked payload for the incoming block.
    always_comb begin
        w_cls_data = '0;
        w_cls_tag  = '0;
        w_cls_len  = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_cls_tag[i*TAG_WIDTH +: TAG_WIDTH] =
                classify(dataIn[i*DATA_WIDTH +: DATA_WIDTH], bypassIn);
            w_cls_data[i*DATA_WIDTH +: DATA_WIDTH] = dataIn[i*DATA_WIDTH +: DATA_WIDTH] &
                payload_mask(tag_e'(w_cls_tag[i*TAG_WIDTH +: TAG_WIDTH]));
            w_cls_len[i*LEN_WIDTH +: LEN_WIDTH] =
                LEN_WIDTH'(tag_len(tag_e'(w_cls_tag[i*TAG_WIDTH +: TAG_WIDTH]), DATA_WIDTH));
        end
    end

    assign w_ld0    = ~r_v0 | g_lvl[1].w_ld;
    assign readyOut = w_ld0;

    // Classify stage register; it captures only on an accepted block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_d0 <= '0;
            r_t0 <= '0;
            r_l0 <= '0;
        end else if (w_ld0) begin
            r_v0 <= validIn;
            if (validIn) begin
                r_d0 <= w_cls_data;
                r_t0 <= w_cls_tag;
                r_l0 <= w_cls_len;
            end
        end
    end

    for (genvar k = 1; k <= LOG; k++) begin : g_lvl
        localparam int CNT_IN  = NUM_LANES >> (k - 1);
        localparam int NODE_W  = DATA_WIDTH << (k - 1);
        localparam int NODE_TW = TAG_WIDTH << (k - 1);

        logic                              w_v_in;
        logic                              w_ld_next;
        logic                              w_ld;
        logic                              w_v;
        logic [TOT_D-1:0]                  w_d_in;
        logic [TOT_D-1:0]                  w_d;
        logic [TOT_T-1:0]                  w_t_in;
        logic [TOT_T-1:0]                  w_t;
        logic [CNT_IN*LEN_WIDTH-1:0]       w_l_in;
        logic [(CNT_IN/2)*LEN_WIDTH-1:0]   w_l;

        if (k == 1) begin : g_src
            assign w_v_in = r_v0;
            assign w_d_in = r_d0;
            assign w_t_in = r_t0;
            assign w_l_in = r_l0;
        end else begin : g_src
            assign w_v_in = g_lvl[k-1].w_v;
            assign w_d_in = g_lvl[k-1].w_d;
            assign w_t_in = g_lvl[k-1].w_t;
            assign w_l_in = g_lvl[k-1].w_l;
        end

        if (k == LOG) begin : g_snk
            assign w_ld_next = readyIn;
        end else begin : g_snk
            assign w_ld_next = g_lvl[k+1].w_ld;
        end

        cpr_merge_stage #(
            .NODE_W   (NODE_W),
            .NODE_CNT (CNT_IN),
            .NODE_TW  (NODE_TW),
            .LEN_W    (LEN_WIDTH)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .i_valid   (w_v_in),
            .i_ld_next (w_ld_next),
            .o_ld      (w_ld),
            .o_valid   (w_v),
            .i_data    (w_d_in),
            .i_tag     (w_t_in),
            .i_len     (w_l_in),
            .o_data    (w_d),
            .o_tag     (w_t),
            .o_len     (w_l)
        );
    end

    assign validOut   = g_lvl[LOG].w_v;
    assign dataOut    = g_lvl[LOG].w_d;
    assign tagOut     = g_lvl[LOG].w_t;
    assign lenOut     = g_lvl[LOG].w_l;
    assign w_fire     = validOut & readyIn;
    assign statBlocks = r_stat_blocks;
    assign statBits   = r_stat_bits;

    // Saturating throughput counters; clear takes priority over a handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_blocks <= '0;
            r_stat_bits   <= '0;
        end else if (statClear) begin
            r_stat_blocks <= '0;
            r_stat_bits   <= '0;
        end else if (w_fire) begin
            r_stat_blocks <= STAT_WIDTH'(sat_add(64'(r_stat_blocks), 64'd1, STAT_MAX));
            r_stat_bits   <= STAT_WIDTH'(sat_add(64'(r_stat_bits), 64'(lenOut), STAT_MAX));
        end
    end

endmodule

// File: tb/tb_nlane_compress_pipe.sv
// Bench for nlane_compress_pipe: scoreboard fed on accept, checked on output
// handshake, plus directed checks of packing, bypass, stalls and counters.
module tb_nlane_compress_pipe;

    localparam int NL    = 8;
    localparam int DW    = 32;
    localparam int LW    = 16;
    localparam int SW    = 10;
    localparam int TOT   = NL * DW;
    localparam int EW    = LW + 2 * NL + TOT;
    localparam int DEPTH = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           validIn = 1'b0;
    logic           readyOut;
    logic [TOT-1:0] dataIn = '0;
    logic           bypassIn = 1'b0;
    logic           validOut;
    logic           readyIn = 1'b1;
    logic [TOT-1:0] dataOut;
    logic [2*NL-1:0] tagOut;
    logic [LW-1:0]  lenOut;
    logic           statClear = 1'b0;
    logic [SW-1:0]  statBlocks;
    logic [SW-1:0]  statBits;

    nlane_compress_pipe #(
        .NUM_LANES  (NL),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (2),
        .LEN_WIDTH  (LW),
        .STAT_WIDTH (SW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .validIn    (validIn),
        .readyOut   (readyOut),
        .dataIn     (dataIn),
        .bypassIn   (bypassIn),
        .validOut   (validOut),
        .readyIn    (readyIn),
        .dataOut    (dataOut),
        .tagOut     (tagOut),
        .lenOut     (lenOut),
        .statClear  (statClear),
        .statBlocks (statBlocks),
        .statBits   (statBits)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, obs, exp);
        end
    endtask

    // Reference model: classify each lane by its signed range and append the
    // payload bits sequentially from bit 0.
    function automatic logic [EW-1:0] model(input logic [TOT-1:0] d, input logic b);
        logic [TOT-1:0]  pk;
        logic [2*NL-1:0] tg;
        int              pos;
        pk  = '0;
        tg  = '0;
        pos = 0;
        for (int i = 0; i < NL; i++) begin
            logic signed [DW-1:0] w;
            logic [DW-1:0]        wu;
            int                   l;
            logic [1:0]           t;
            w  = d[i*DW +: DW];
            wu = w;
            if (b)                             begin t = 2'd3; l = DW; end
            else if (w == 0)                   begin t = 2'd0; l = 0;  end
            else if (w >= -128 && w <= 127)    begin t = 2'd1; l = 8;  end
            else if (w >= -32768 && w <= 32767) begin t = 2'd2; l = 16; end
            else                               begin t = 2'd3; l = DW; end
            pk = pk | ((TOT'(wu) & ((TOT'(1) << l) - TOT'(1))) << pos);
            tg[2*i +: 2] = t;
            pos += l;
        end
        return {LW'(pos), tg, pk};
    endfunction

    function automatic logic [TOT-1:0] rand_block();
        logic [TOT-1:0] blk;
        blk = '0;
        for (int i = 0; i < NL; i++) begin
            logic [31:0] r;
            r = $urandom;
            case ($urandom_range(0, 3))
                0:       blk[i*DW +: DW] = '0;
                1:       blk[i*DW +: DW] = {{24{r[7]}}, r[7:0]};
                2:       blk[i*DW +: DW] = {{16{r[15]}}, r[15:0]};
                default: blk[i*DW +: DW] = r;
            endcase
        end
        return blk;
    endfunction

    // Scoreboard and protocol monitor
    logic [EW-1:0] exp_q[$];
    logic          stall_prev = 1'b0;
    logic          full_fire_prev = 1'b0;
    logic [EW-1:0] held = '0;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall_prev     = 1'b0;
            full_fire_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_valid", EW'(validOut), EW'(1));
                check("stall_hold", {lenOut, tagOut, dataOut}, held);
            end
            if (full_fire_prev) check("sustain", EW'(validOut), EW'(1));
            full_fire_prev = 1'b0;
            if (!readyOut) check("full_depth", EW'(exp_q.size()), EW'(DEPTH));
            if (validOut && readyIn) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", EW'(validOut), EW'(0));
                end else begin
                    full_fire_prev = (exp_q.size() == DEPTH);
                    check("out_block", {lenOut, tagOut, dataOut}, exp_q.pop_front());
                end
            end
            if (validIn && readyOut) exp_q.push_back(model(dataIn, bypassIn));
            stall_prev = validOut && !readyIn;
            held       = {lenOut, tagOut, dataOut};
        end
    end

    // Driver tasks: entered and left just after a rising edge.
    task automatic send_block(input logic [TOT-1:0] d, input logic b);
        validIn  = 1'b1;
        dataIn   = d;
        bypassIn = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (readyOut) break;
        end
        if (!readyOut) check("accept_timeout", EW'(readyOut), EW'(1));
        @(posedge clk);
        #1;
        validIn = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && !validOut) break;
        end
        check("drain", EW'(exp_q.size()), EW'(0));
    endtask

    // Leaves the caller at the falling edge where validOut is seen.
    task automatic wait_valid();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (validOut) break;
        end
        check("valid_timeout", EW'(validOut), EW'(1));
    endtask

    logic [TOT-1:0] blk1;
    logic [TOT-1:0] exp_pack1;
    int             lat;

    initial begin
        blk1      = {32'h1, 32'h0, 32'h12345678, 32'hFFFF8000,
                     32'h1234, 32'hFFFFFF80, 32'h7F, 32'h0};
        exp_pack1 = TOT'(88'h01_12345678_8000_1234_80_7F);

        // Reset state
        #1;
        check("rst_valid", EW'(validOut), EW'(0));
        check("rst_outs", {lenOut, tagOut, dataOut}, EW'(0));
        check("rst_stats", EW'({statBlocks, statBits}), EW'(0));
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", EW'(readyOut), EW'(1));

        // 1. Classification, packing and latency
        send_block(blk1, 1'b0);
        lat = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (validOut) break;
            lat++;
            @(posedge clk);
        end
        check("latency", EW'(lat), EW'(4));
        check("t1_len", EW'(lenOut), EW'(88));
        check("t1_tag", EW'(tagOut), EW'(16'h4E94));
        check("t1_data", EW'(dataOut), EW'(exp_pack1));
        @(posedge clk);
        #1;
        wait_drain();

        // 2. Bypass, then an all-zero block
        send_block(blk1, 1'b1);
        wait_valid();
        check("t2_tag", EW'(tagOut), EW'(16'hFFFF));
        check("t2_len", EW'(lenOut), EW'(256));
        check("t2_data", EW'(dataOut), EW'(blk1));
        @(posedge clk);
        #1;
        send_block('0, 1'b0);
        wait_valid();
        check("t2z_outs", {lenOut, tagOut, dataOut}, EW'(0));
        @(posedge clk);
        #1;
        wait_drain();

        // 3. Backpressure with back-to-back blocks
        fork
            begin
                for (int c = 0; c < 12; c++) begin
                    readyIn = (c < 3 || c > 8);
                    if (c == 7) check("t3_ready_low", EW'(readyOut), EW'(0));
                    @(posedge clk);
                    #1;
                end
                readyIn = 1'b1;
            end
            begin
                for (int i = 1; i <= 10; i++) send_block(rand_block(), 1'b0);
            end
        join
        wait_drain();

        // 4. Bubble collapse under a stalled output
        readyIn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            validIn  = (i % 2 == 0);
            dataIn   = rand_block();
            bypassIn = 1'b0;
            @(posedge clk);
            #1;
        end
        validIn = 1'b0;
        check("t4_ready", EW'(readyOut), EW'(0));
        check("t4_held", EW'(exp_q.size()), EW'(DEPTH));
        readyIn = 1'b1;
        wait_drain();

        // 5. Counters
        statClear = 1'b1;
        @(posedge clk);
        #1;
        statClear = 1'b0;
        check("t5_clr_blocks", EW'(statBlocks), EW'(0));
        check("t5_clr_bits", EW'(statBits), EW'(0));
        for (int i = 0; i < 3; i++) send_block(rand_block(), 1'b1);
        wait_drain();
        check("t5_bits3", EW'(statBits), EW'(768));
        check("t5_blocks3", EW'(statBlocks), EW'(3));
        send_block(rand_block(), 1'b1);
        wait_drain();
        check("t5_bits_sat", EW'(statBits), EW'(1023));
        check("t5_blocks4", EW'(statBlocks), EW'(4));
        send_block(blk1, 1'b0);
        wait_valid();
        statClear = 1'b1;
        @(posedge clk);
        #1;
        statClear = 1'b0;
        check("t5_clr_hs_blocks", EW'(statBlocks), EW'(0));
        check("t5_clr_hs_bits", EW'(statBits), EW'(0));
        wait_drain();

        // 6. Reset with blocks in flight
        for (int i = 0; i < 3; i++) send_block(rand_block(), 1'b0);
        reset = 1'b1;
        #1;
        check("t6_valid", EW'(validOut), EW'(0));
        check("t6_outs", {lenOut, tagOut, dataOut}, EW'(0));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("t6_ready", EW'(readyOut), EW'(1));
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_stale", EW'(validOut), EW'(0));
        send_block(blk1, 1'b0);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
